// File: rtl/vr_pkg.sv
// Shared types for the valid/ready sequence source.
// Holds the FSM state enum and the default LFSR tap mask.
package vr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] LFSR_TAPS_DEFAULT = 8'hB8;

endpackage

// File: rtl/valid_ready.sv
// Valid/ready handshake bundle.
// Master drives valid/data, Slave drives ready.
interface valid_ready #(
  parameter int DATA_WIDTH = 8
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport Master (
    output valid,
    output data,
    input  ready
  );

  modport Slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/vr_seq_gen.sv
// Sequence value generator: latches mode/seed, advances count or LFSR.
// Ports: clk, reset, i_load/i_mode/i_seed (latch), i_advance, o_data.
module vr_seq_gen
  import vr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  =
    DATA_WIDTH'(LFSR_TAPS_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_mode,
  input  logic [DATA_WIDTH-1:0] i_seed,
  input  logic                  i_advance,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_mode;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_next;
  logic [DATA_WIDTH-1:0] w_seed;

  // An all-zero LFSR would lock up, so seed 0 becomes 1.
  assign w_seed = (i_mode && (i_seed == '0))
                ? DATA_WIDTH'(1) : i_seed;

  always_comb begin
    w_next = r_data + 1'b1;
    if (r_mode) begin
      w_next = (r_data >> 1)
             ^ (r_data[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_mode <= i_mode;
      r_data <= w_seed;
    end else if (i_advance) begin
      r_data <= w_next;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/vr_seq_source.sv
// Burst source: emits length beats on a valid/ready bus with gaps.
// Ports: clk, reset, start/mode/seed/length/gap, busy, done, txBus.
module vr_seq_source
  import vr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    LEN_WIDTH  = 8,
  parameter int                    GAP_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  =
    DATA_WIDTH'(LFSR_TAPS_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [GAP_WIDTH-1:0]  gap,
  output logic                  busy,
  output logic                  done,
  valid_ready.Master            txBus
);

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic [GAP_WIDTH-1:0]  r_gap;
  logic [GAP_WIDTH-1:0]  r_gap_cnt;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_data;

  assign w_load   = (r_state == ST_IDLE) && start;
  assign w_accept = (r_state == ST_SEND) && txBus.ready;
  // Beat being accepted is the final one of the burst.
  assign w_last   = (r_beat_cnt + 1'b1) == r_len;

  vr_seq_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .LFSR_TAPS  (LFSR_TAPS)
  ) u_gen (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_mode    (mode),
    .i_seed    (seed),
    .i_advance (w_accept),
    .o_data    (w_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_gap      <= '0;
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len      <= length;
            r_gap      <= gap;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
            r_state    <= (length == '0)
                        ? ST_DONE : ST_SEND;
          end
        end
        ST_SEND: begin
          if (txBus.ready) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_last) begin
              r_state <= ST_DONE;
            end else if (r_gap != '0) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= r_gap;
            end
          end
        end
        ST_GAP: begin
          // Counter holds remaining gap cycles incl. this one.
          if (r_gap_cnt <= 1) begin
            r_state   <= ST_SEND;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign txBus.valid = (r_state == ST_SEND);
  assign txBus.data  = w_data;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_vr_seq_source.sv
// Directed bench for vr_seq_source.
// Drives and samples 1ns after each rising edge.
module tb_vr_seq_source;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] seed;
  logic [7:0] length;
  logic [3:0] gap;
  logic       busy;
  logic       done;

  int n_chk = 0;
  int n_err = 0;

  valid_ready #(.DATA_WIDTH(8)) bus ();

  vr_seq_source #(
    .DATA_WIDTH (8),
    .LEN_WIDTH  (8),
    .GAP_WIDTH  (4),
    .LFSR_TAPS  (8'hB8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .seed   (seed),
    .length (length),
    .gap    (gap),
    .busy   (busy),
    .done   (done),
    .txBus  (bus.Master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a burst, then scramble inputs to show they are ignored.
  task automatic go(input logic m, input logic [7:0] s,
                    input logic [7:0] l, input logic [3:0] g);
    mode   = m;
    seed   = s;
    length = l;
    gap    = g;
    start  = 1'b1;
    step();
    start  = 1'b0;
    mode   = ~m;
    seed   = 8'h5A;
    length = 8'd1;
    gap    = 4'd7;
  endtask

  task automatic beat(input string tag, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(bus.valid), 32'd1);
    chk({tag, ".data"}, 32'(bus.data), 32'(d));
  endtask

  task automatic idle_beat(input string tag);
    chk({tag, ".valid"}, 32'(bus.valid), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
  endtask

  task automatic fin(input string tag);
    chk({tag, ".dvalid"}, 32'(bus.valid), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".dbusy"}, 32'(busy), 32'd1);
    step();
    chk({tag, ".done0"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    seed      = 8'h00;
    length    = 8'd0;
    gap       = 4'd0;
    bus.ready = 1'b1;
    step();
    step();
    chk("rst.valid", 32'(bus.valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.data", 32'(bus.data), 32'd0);
    reset = 1'b0;
    step();

    // Count wrap, with a stray start mid-burst
    go(1'b0, 8'hFE, 8'd4, 4'd0);
    beat("wrap0", 8'hFE);
    chk("wrap.busy", 32'(busy), 32'd1);
    start = 1'b1;
    seed  = 8'h33;
    step();
    start = 1'b0;
    beat("wrap1", 8'hFF);
    step();
    beat("wrap2", 8'h00);
    step();
    beat("wrap3", 8'h01);
    step();
    fin("wrap");

    // Backpressure on beat 2
    go(1'b0, 8'hFE, 8'd4, 4'd0);
    beat("bp0", 8'hFE);
    step();
    for (int i = 0; i < 3; i++) begin
      bus.ready = 1'b0;
      beat($sformatf("bp_hold%0d", i), 8'hFF);
      step();
    end
    bus.ready = 1'b1;
    beat("bp_hold3", 8'hFF);
    step();
    beat("bp2", 8'h00);
    step();
    beat("bp3", 8'h01);
    step();
    fin("bp");

    // Gap of 2
    go(1'b0, 8'h10, 8'd3, 4'd2);
    beat("gap0", 8'h10);
    step();
    idle_beat("gap0a");
    step();
    idle_beat("gap0b");
    step();
    beat("gap1", 8'h11);
    step();
    idle_beat("gap1a");
    step();
    idle_beat("gap1b");
    step();
    beat("gap2", 8'h12);
    step();
    fin("gap");

    // LFSR
    go(1'b1, 8'h01, 8'd4, 4'd0);
    beat("lfsr0", 8'h01);
    step();
    beat("lfsr1", 8'hB8);
    step();
    beat("lfsr2", 8'h5C);
    step();
    beat("lfsr3", 8'h2E);
    step();
    fin("lfsr");

    // LFSR zero seed
    go(1'b1, 8'h00, 8'd1, 4'd0);
    beat("lfsrz", 8'h01);
    step();
    fin("lfsrz");

    // Zero length
    go(1'b0, 8'h77, 8'd0, 4'd0);
    fin("zlen");

    // Reset mid-burst
    go(1'b0, 8'h20, 8'd8, 4'd0);
    beat("rb0", 8'h20);
    step();
    beat("rb1", 8'h21);
    #2;
    reset = 1'b1;
    #1;
    chk("rb.valid", 32'(bus.valid), 32'd0);
    chk("rb.busy", 32'(busy), 32'd0);
    chk("rb.done", 32'(done), 32'd0);
    chk("rb.data", 32'(bus.data), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      idle_beat($sformatf("rb_after%0d", i));
      chk("rb.busy_after", 32'(busy), 32'd0);
    end
    go(1'b0, 8'h40, 8'd2, 4'd0);
    beat("rs0", 8'h40);
    step();
    beat("rs1", 8'h41);
    step();
    fin("rs");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
